seq_divider16: RTL
==================

// Module: seq_divider16
// PURPOSE
//  Iterative restoring divider: the inverse of the 16x16 Wallace multiplier path.
//  Takes a 2*W-bit dividend (e.g. a product) and a W-bit divisor; returns a W-bit quotient and remainder.
//  Computes one quotient bit per cycle, with valid/ready handshakes on both sides.
//  Sits beside the multiplier datapath for divide/verify operations.
// PARAMETERS
//  W   16   operand width; dividend is 2*W, quotient and remainder are W each
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     dividend/divisor valid
//  in_ready     out  1     divider can accept (high only in IDLE)
//  dividend     in   2*W   numerator
//  divisor      in   W     denominator
//  out_valid    out  1     result valid; held until taken
//  out_ready    in   1     consumer accepts result
//  quotient     out  W     floor(dividend/divisor)
//  remainder    out  W     dividend - quotient*divisor
//  div_by_zero  out  1     divisor was 0 (valid with out_valid)
//  overflow     out  1     quotient does not fit in W bits (valid with out_valid)
// BEHAVIOUR
//  - Reset is asynchronous and active-low: state=IDLE, count=0, and all outputs 0 except in_ready=1.
//  - Outputs are registered. Nothing changes outside the handshakes below.
//  - States: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. Accept when in_valid is high; operands are latched at that edge (the "accept edge").
//     * divisor==0: div_by_zero=1, overflow=0, quotient={W{1}}, remainder=0; go to DONE.
//     * else dividend[2W-1:W] >= divisor: overflow=1, quotient={W{1}}, remainder=0; go to DONE.
//     * else: partial remainder R (W+1 bits) = {0,dividend[2W-1:W]}; low word goes to the shift register; count=0; go to CALC.
//  - CALC: one step per cycle.
//     * Shift the next low-word bit (MSB first) into R.
//     * If R >= divisor: R = R - divisor and the quotient bit is 1; else the quotient bit is 0.
//     * After W steps (count==W-1): register quotient and remainder=R[W-1:0], flags=0; go to DONE.
//  - DONE: out_valid=1 and all results stay stable. On out_ready: out_valid=0; go to IDLE, in_ready=1 next cycle.
//  - Latency, measured from the accept edge:
//     * normal operation: out_valid rises W+1 edges later (17 for W=16);
//     * divide-by-zero or overflow: out_valid rises 1 edge later.
//  - Throughput: at most one operation in flight. in_valid is ignored outside IDLE; no overlap of accept and result.
//  - out_ready while out_valid=0 has no effect.
//  - in_valid and out_ready in the same cycle: only the DONE->IDLE transition happens. The new operand is accepted on a later cycle.
//  - rst_n asserted mid-CALC or mid-DONE: the operation is abandoned and the registers return to their reset values immediately. There is no partial result.
//  - Width rules:
//     * R is W+1 bits so the compare never truncates.
//     * The subtract is unsigned.
//     * All arithmetic is unsigned; there is no signed mode.
// STRUCTURE
//  - Shared header div_defs.vh: state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the count width localparam clog2(W).
//  - One sub-module, div_step: purely combinational.
//     * Inputs: R_in (W+1), divisor (W).
//     * Outputs: R_out and q_bit.
//     * Implementation: built on the existing ripple full-adder cells, using two's-complement add with the carry-out as the >= test.
//  - seq_divider16 holds the FSM, counter, shift register and output registers.
// TESTING
//  1. dividend=0x00000C00, divisor=0x0030 -> quotient=0x0040, remainder=0x0000, flags 0, out_valid 17 cycles after accept.
//  2. Product inverse: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000, overflow=0.
//  3. dividend=0x000186A3 (100003), divisor=0x0007 -> quotient=0x37CE, remainder=0x0001.
//  4. divisor=0x0000, any dividend -> div_by_zero=1, quotient=0xFFFF, remainder=0, out_valid 1 cycle after accept.
//     Also: dividend=0x00010000, divisor=0x0001 -> overflow=1, div_by_zero=0.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     -> out_valid and the results are stable; in_ready=0; in_valid pulses are ignored.
//     -> Release out_ready: in_ready=1 on the next cycle.
//  6. Reset at CALC step 8: all outputs go to 0 at once, in_ready=1 after release, and the next op (case 3) returns the correct result.
//  Random: 10k random (dividend, divisor) pairs checked against a reference model: q*d+r==dividend, r<d, flags as specified.

Source files
------------

// File: rtl/seq_divider16_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider16_pkg;

    parameter int unsigned DefW = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider16_div_step.sv
// One restoring-division step: trial subtract via a ripple two's-complement add,
// the adder carry-out doubling as the R >= divisor test.
module seq_divider16_div_step
    import seq_divider16_pkg::*;
#(
    parameter int unsigned W = DefW
) (
    input  logic [W:0]   r_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_out,
    output logic         q_bit
);

    logic [W:0]   w_b;
    logic [W+1:0] w_c;
    logic [W-1:0] w_diff;

    always_comb begin
        w_b    = ~{1'b0, divisor};
        w_c    = '0;
        w_c[0] = 1'b1;
        for (int i = 0; i <= W; i++) begin
            w_c[i+1] = (r_in[i] & w_b[i]) | (w_c[i] & (r_in[i] ^ w_b[i]));
        end
        w_diff = '0;
        for (int i = 0; i < W; i++) begin
            w_diff[i] = r_in[i] ^ w_b[i] ^ w_c[i];
        end
    end

    // Either way the new remainder is below the divisor, so W bits always hold it.
    assign q_bit = w_c[W+1];
    assign r_out = q_bit ? w_diff : r_in[W-1:0];

endmodule

// File: rtl/seq_divider16.sv
// Iterative restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit
// per cycle, valid/ready handshakes on both sides and registered outputs.
module seq_divider16
    import seq_divider16_pkg::*;
#(
    parameter int unsigned W = DefW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CntW = cnt_width(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    state_e          r_state;
    logic [CntW-1:0] r_count;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    r_divisor;

    logic [W:0]      w_r_in;
    logic [W-1:0]    w_r_out;
    logic            w_q_bit;
    logic            w_div_zero;
    logic            w_high_ge;

    assign w_r_in     = {r_rem, r_shift[W-1]};
    assign w_div_zero = (divisor == '0);
    assign w_high_ge  = (dividend[2*W-1:W] >= divisor);

    seq_divider16_div_step #(
        .W (W)
    ) u_step (
        .r_in    (w_r_in),
        .divisor (r_divisor),
        .r_out   (w_r_out),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_rem       <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (w_div_zero) begin
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= '0;
                            r_state     <= StDone;
                        end else if (w_high_ge) begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            r_state     <= StDone;
                        end else begin
                            r_rem     <= dividend[2*W-1:W];
                            r_shift   <= dividend[W-1:0];
                            r_divisor <= divisor;
                            r_count   <= '0;
                            r_state   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    // Dividend bits leave the top of r_shift as quotient bits enter the bottom.
                    r_rem   <= w_r_out;
                    r_shift <= {r_shift[W-2:0], w_q_bit};
                    r_count <= r_count + 1'b1;
                    if (r_count == LastCnt) begin
                        quotient    <= {r_shift[W-2:0], w_q_bit};
                        remainder   <= w_r_out;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
